dsp_operand_skid: RTL and testbench



---
 rtl/dsp_pkg.sv | 22 ++
 rtl/dsp_operand_pack.sv | 21 ++
 rtl/dsp_operand_skid.sv | 110 +++++++++++
 tb/tb_dsp_operand_skid.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared definitions for the DSP48E2 wrapper operand stages: port field
// widths, the packed operand layout and the skid buffer state encoding.
package dsp_pkg;

  localparam int DSP_A_W      = 30;
  localparam int DSP_B_W      = 18;
  localparam int DSP_C_W      = 48;
  localparam int DSP_AB_SPLIT = 18;

  typedef struct packed {
    logic [DSP_A_W-1:0] a;
    logic [DSP_B_W-1:0] b;
    logic [DSP_C_W-1:0] c;
  } dsp_operand_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/dsp_operand_pack.sv
// Zero-extends a width-bit operand pair to 48 bits and splits b across the
// DSP A:B concatenation; a goes straight to C.
module dsp_operand_pack
  import dsp_pkg::*;
#(
  parameter int width = 48
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output dsp_operand_t     operand
);

  logic [DSP_C_W-1:0] ext_b;

  // Unsigned casts zero-extend, which also covers width == 48 cleanly.
  assign ext_b     = DSP_C_W'(b);
  assign operand.a = ext_b[DSP_C_W-1:DSP_AB_SPLIT];
  assign operand.b = ext_b[DSP_AB_SPLIT-1:0];
  assign operand.c = DSP_C_W'(a);

endmodule

// File: rtl/dsp_operand_skid.sv
// Two-entry skid buffer feeding pre-split operands to the DSP wrappers.
// Handshake: a pair moves when valid & ready are both high at a rising edge.
module dsp_operand_skid
  import dsp_pkg::*;
#(
  parameter int width = 48
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [width-1:0]   a,
  input  logic [width-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DSP_A_W-1:0] dsp_a,
  output logic [DSP_B_W-1:0] dsp_b,
  output logic [DSP_C_W-1:0] dsp_c
);

  if (width < 1 || width > 48) begin : g_bad_width
    $error("[dsp_operand_skid] width:%d configuration not supported", width);
  end

  dsp_operand_t packed_in;
  dsp_operand_t main_q;
  dsp_operand_t skid_q;
  skid_state_t  state;
  skid_state_t  next_state;
  logic         accept;
  logic         take;
  logic         load_main_in;
  logic         load_main_skid;
  logic         load_skid;

  dsp_operand_pack #(.width(width)) u_pack (
    .a       (a),
    .b       (b),
    .operand (packed_in)
  );

  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign take      = out_valid & out_ready;

  always_comb begin
    next_state     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          next_state   = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && !take) begin
          next_state = FULL;
          load_skid  = 1'b1;
        end else if (accept && take) begin
          load_main_in = 1'b1;
        end else if (take) begin
          next_state = EMPTY;
        end
      end
      FULL: begin
        if (take) begin
          next_state     = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: next_state = EMPTY;
    endcase
  end

  // in_ready looks only at next_state, so there is no combinational path
  // from either handshake input to it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= EMPTY;
      in_ready <= 1'b0;
    end else begin
      state    <= next_state;
      in_ready <= (next_state != FULL);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= packed_in;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= packed_in;
      end
    end
  end

  assign dsp_a = main_q.a;
  assign dsp_b = main_q.b;
  assign dsp_c = main_q.c;

endmodule

// File: tb/tb_dsp_operand_skid.sv
// Bench for dsp_operand_skid: directed and random traffic on a width=16
// instance plus a directed width=48 packing check on a second instance.
module tb_dsp_operand_skid;

  localparam int W = 16;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  a, b;
  logic [29:0]   dsp_a;
  logic [17:0]   dsp_b;
  logic [47:0]   dsp_c;

  logic          in_valid48, in_ready48, out_valid48, out_ready48;
  logic [47:0]   a48, b48;
  logic [29:0]   dsp_a48;
  logic [17:0]   dsp_b48;
  logic [47:0]   dsp_c48;

  dsp_operand_skid #(.width(W)) dut (
    .clock(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_c(dsp_c)
  );

  dsp_operand_skid #(.width(48)) dut48 (
    .clock(clk), .reset(reset), .in_valid(in_valid48), .in_ready(in_ready48),
    .a(a48), .b(b48), .out_valid(out_valid48), .out_ready(out_ready48),
    .dsp_a(dsp_a48), .dsp_b(dsp_b48), .dsp_c(dsp_c48)
  );

  // scoreboard
  logic [95:0] exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  n_out   = 0;
  int  n_acc   = 0;
  bit  armed;
  bit  last_acc;

  // Reference packing: A:B is b as a 48-bit number split at 2**18; C is a.
  function automatic logic [95:0] model(input logic [47:0] av, input logic [47:0] bv);
    logic [29:0] ma;
    logic [17:0] mb;
    ma = 30'(bv / 48'd262144);
    mb = 18'(bv % 48'd262144);
    return {ma, mb, av};
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // in_ready becomes legal one edge after reset is released
  always @(posedge clk or posedge reset) begin
    if (reset) armed <= 1'b0;
    else       armed <= 1'b1;
  end

  // monitor: inputs are stable around the negedge, so this sees what the
  // DUT will act on at the next rising edge
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      last_acc = 1'b0;
      chk("reset_in_ready", 96'(in_ready), 96'd0);
      chk("reset_out_valid", 96'(out_valid), 96'd0);
      chk("reset_data", {dsp_a, dsp_b, dsp_c}, 96'd0);
    end else begin
      chk("in_ready", 96'(in_ready), 96'(armed && exp_q.size() < 2));
      chk("out_valid", 96'(out_valid), 96'(exp_q.size() != 0));
      last_acc = in_valid & in_ready;
      if (out_valid && exp_q.size() != 0) begin
        chk("data", {dsp_a, dsp_b, dsp_c}, exp_q[0]);
        if (out_ready) begin
          void'(exp_q.pop_front());
          n_out++;
        end
      end
      if (last_acc) begin
        exp_q.push_back(model(48'(a), 48'(b)));
        n_acc++;
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    chk("drained", 96'(out_valid), 96'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_out, base_acc, i;
    logic [47:0] ra;

    reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    in_valid48 = 1'b0; out_ready48 = 1'b0; a48 = '0; b48 = '0;
    repeat (3) step();
    reset = 1'b0;
    chk("in_ready_before_edge", 96'(in_ready), 96'd0);
    step();
    chk("in_ready_after_reset", 96'(in_ready), 96'd1);

    // single transfer, width 16
    a = 16'hBEEF; b = 16'hF00D; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("single_valid", 96'(out_valid), 96'd1);
    chk("single_dsp_c", 96'(dsp_c), 96'(48'h00000000BEEF));
    chk("single_dsp_b", 96'(dsp_b), 96'(18'h0F00D));
    chk("single_dsp_a", 96'(dsp_a), 96'(30'h0));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // width 48, all-ones b
    ra = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
    a48 = ra; b48 = 48'hFFFF_FFFF_FFFF; in_valid48 = 1'b1;
    step();
    in_valid48 = 1'b0;
    chk("w48_valid", 96'(out_valid48), 96'd1);
    chk("w48_dsp_a", 96'(dsp_a48), 96'(30'h3FFFFFFF));
    chk("w48_dsp_b", 96'(dsp_b48), 96'(18'h3FFFF));
    chk("w48_dsp_c", 96'(dsp_c48), 96'(ra));
    out_ready48 = 1'b1;
    step();
    chk("w48_released", 96'(out_valid48), 96'd0);
    out_ready48 = 1'b0;

    // backpressure: 1 and 2 fill the buffer, 3 must wait
    drain();
    out_ready = 1'b0;
    base_acc = n_acc;
    a = 16'd1; b = 16'd1; in_valid = 1'b1;
    step();
    a = 16'd2; b = 16'd2;
    step();
    a = 16'd3; b = 16'd3;
    chk("bp_full_ready", 96'(in_ready), 96'd0);
    repeat (2) step();
    chk("bp_still_full", 96'(in_ready), 96'd0);
    chk("bp_two_accepts", 96'(n_acc - base_acc), 96'd2);
    out_ready = 1'b1;
    for (i = 0; i < 10; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    chk("bp_ready_timeout", 96'(i < 10), 96'd1);
    step();
    in_valid = 1'b0;
    chk("bp_third_accept", 96'(n_acc - base_acc), 96'd3);
    drain();

    // streaming, 100 pairs back to back
    base_out = n_out;
    base_acc = n_acc;
    out_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      a = W'(k + 16'h100); b = W'(16'hFFFF - k); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step();
    chk("stream_accepts", 96'(n_acc - base_acc), 96'd100);
    chk("stream_outputs", 96'(n_out - base_out), 96'd100);

    // random traffic; the producer holds a/b while stalled
    for (int k = 0; k < 400; k++) begin
      if (!(in_valid && !last_acc)) begin
        in_valid = 1'($urandom_range(0, 1));
        a = W'($urandom);
        b = W'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    // fill to FULL, then reset mid-cycle
    out_ready = 1'b0;
    in_valid = 1'b1;
    a = 16'h1111; b = 16'h2222;
    for (i = 0; i < 10; i++) begin
      step();
      if (!in_ready) break;
    end
    chk("fill_timeout", 96'(i < 10), 96'd1);
    in_valid = 1'b0;
    #3 reset = 1'b1;
    #1;
    chk("async_out_valid", 96'(out_valid), 96'd0);
    chk("async_in_ready", 96'(in_ready), 96'd0);
    step();
    step();
    reset = 1'b0;
    base_out = n_out;
    out_ready = 1'b1;
    step();
    chk("post_reset_idle", 96'(out_valid), 96'd0);
    a = 16'h005A; b = 16'h00A5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("post_reset_dsp_c", 96'(dsp_c), 96'(48'h5A));
    chk("post_reset_dsp_b", 96'(dsp_b), 96'(18'hA5));
    repeat (3) step();
    chk("post_reset_count", 96'(n_out - base_out), 96'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
